// File: rtl/jtframe_sdram_arb.sv
// SDRAM bank arbiter: NCH game channels plus one debug-CPU channel share a
// single controller bank port. Fixed or round-robin priority, with a
// starvation guard that forces the debug channel through after MAXWAIT losses.
module jtframe_sdram_arb #(
    parameter int AW      = 22,
    parameter int NCH     = 2,
    parameter int RR      = 0,
    parameter int MAXWAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    // game channels
    input  logic [NCH*AW-1:0]   ch_addr,
    input  logic [NCH-1:0]      ch_rd,
    input  logic [NCH-1:0]      ch_wr,
    input  logic [NCH*16-1:0]   ch_din,
    input  logic [NCH*2-1:0]    ch_din_m,
    output logic [NCH-1:0]      ch_ack,
    output logic [NCH-1:0]      ch_dst,
    output logic [NCH-1:0]      ch_rdy,
    // debug CPU channel
    input  logic                dbg_req,
    input  logic                dbg_we,
    input  logic [AW-1:0]       dbg_addr,
    input  logic [15:0]         dbg_din,
    input  logic [1:0]          dbg_din_m,
    input  logic                locked,
    output logic                dbg_busy,
    output logic [15:0]         dbg_dout,
    output logic [NCH:0]        owner,
    // controller bank port
    output logic [AW-1:0]       ba_addr,
    output logic                ba_rd,
    output logic                ba_wr,
    output logic [15:0]         ba_din,
    output logic [1:0]          ba_din_m,
    input  logic                ba_ack,
    input  logic                ba_dst,
    input  logic                ba_rdy,
    input  logic [15:0]         data_read
);
    localparam int          N   = NCH + 1;
    localparam int          PW  = $clog2(N);
    localparam logic [PW:0] NL  = (PW+1)'(N);
    localparam logic [7:0]  MW  = 8'(MAXWAIT);

    typedef enum logic { IDLE, BUSY } state_t;

    state_t          state;
    logic            pending;
    logic            dbg_we_r;
    logic [7:0]      wait_cnt;
    logic [PW-1:0]   rr_ptr;
    logic [NCH:0]    cand;
    logic [NCH:0]    winner;
    logic [PW-1:0]   win_idx;
    logic            found;
    logic [PW:0]     sidx;
    logic            busy_st;
    logic            mux_rd;
    logic            mux_wr;

    assign busy_st = (state == BUSY);
    assign cand    = {pending, ch_rd | ch_wr};

    // Pick a one-hot winner among the candidates: starvation override first,
    // then either lowest index or a rotating search from rr_ptr.
    always_comb begin
        winner  = '0;
        win_idx = '0;
        found   = 1'b0;
        sidx    = '0;
        if (pending && wait_cnt == MW) begin
            winner[NCH] = 1'b1;
            win_idx     = PW'(NCH);
        end else begin
            for (int i = 0; i < N; i++) begin
                if (RR != 0) begin
                    sidx = {1'b0, rr_ptr} + (PW+1)'(i);
                    if (sidx >= NL) sidx = sidx - NL;
                end else begin
                    sidx = (PW+1)'(i);
                end
                if (!found && cand[sidx[PW-1:0]]) begin
                    found                   = 1'b1;
                    winner[sidx[PW-1:0]]    = 1'b1;
                    win_idx                 = sidx[PW-1:0];
                end
            end
        end
    end

    // Arbitration FSM, debug request bookkeeping and read-back latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            pending  <= 1'b0;
            dbg_we_r <= 1'b0;
            dbg_busy <= 1'b0;
            dbg_dout <= 16'h0;
            wait_cnt <= 8'h0;
            rr_ptr   <= '0;
        end else begin
            if (dbg_req && !locked && !dbg_busy) begin
                pending  <= 1'b1;
                dbg_we_r <= dbg_we;
                dbg_busy <= 1'b1;
            end else begin
                if (busy_st && owner[NCH] && ba_ack) pending  <= 1'b0;
                if (busy_st && owner[NCH] && ba_rdy) dbg_busy <= 1'b0;
            end
            if (busy_st && owner[NCH] && ba_dst) dbg_dout <= data_read;

            case (state)
                IDLE: if (|cand) begin
                    owner  <= winner;
                    state  <= BUSY;
                    rr_ptr <= (win_idx == PW'(NCH)) ? '0 : win_idx + 1'b1;
                    if (winner[NCH])
                        wait_cnt <= 8'h0;
                    else if (pending && wait_cnt != 8'hff)
                        wait_cnt <= wait_cnt + 8'h1;
                end
                BUSY: if (ba_rdy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bank-side mux: the owner's fields pass straight through; strobes only
    // while a transaction is in flight.
    always_comb begin
        ba_addr  = '0;
        ba_din   = 16'h0;
        ba_din_m = 2'b0;
        mux_rd   = 1'b0;
        mux_wr   = 1'b0;
        for (int n = 0; n < NCH; n++) begin
            ba_addr  = ba_addr  | ({AW{owner[n]}} & ch_addr[n*AW +: AW]);
            ba_din   = ba_din   | ({16{owner[n]}} & ch_din[n*16 +: 16]);
            ba_din_m = ba_din_m | ({2{owner[n]}}  & ch_din_m[n*2 +: 2]);
            mux_rd   = mux_rd   | (owner[n] & ch_rd[n]);
            mux_wr   = mux_wr   | (owner[n] & ch_wr[n]);
        end
        ba_addr  = ba_addr  | ({AW{owner[NCH]}} & dbg_addr);
        ba_din   = ba_din   | ({16{owner[NCH]}} & dbg_din);
        ba_din_m = ba_din_m | ({2{owner[NCH]}}  & dbg_din_m);
        mux_rd   = mux_rd   | (owner[NCH] & pending & ~dbg_we_r);
        mux_wr   = mux_wr   | (owner[NCH] & pending &  dbg_we_r);
        ba_rd    = busy_st & mux_rd;
        ba_wr    = busy_st & mux_wr;
    end

    // Completion strobes go back only to the owning game channel.
    assign ch_ack = {NCH{ba_ack & busy_st}} & owner[NCH-1:0];
    assign ch_dst = {NCH{ba_dst & busy_st}} & owner[NCH-1:0];
    assign ch_rdy = {NCH{ba_rdy & busy_st}} & owner[NCH-1:0];

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Directed bench for jtframe_sdram_arb: a fixed-priority instance (MAXWAIT=3)
// and a round-robin instance driven from the same stimulus.
module tb_jtframe_sdram_arb;
    localparam int AW  = 22;
    localparam int NCH = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH-1:0]    ch_rd, ch_wr;
    logic [NCH*16-1:0] ch_din;
    logic [NCH*2-1:0]  ch_din_m;
    logic              dbg_req, dbg_we, locked;
    logic [AW-1:0]     dbg_addr;
    logic [15:0]       dbg_din;
    logic [1:0]        dbg_din_m;
    logic              ba_ack, ba_dst, ba_rdy;
    logic [15:0]       data_read;

    // fixed-priority instance outputs
    logic [NCH-1:0]    ch_ack, ch_dst, ch_rdy;
    logic              dbg_busy;
    logic [15:0]       dbg_dout;
    logic [NCH:0]      owner;
    logic [AW-1:0]     ba_addr;
    logic              ba_rd, ba_wr;
    logic [15:0]       ba_din;
    logic [1:0]        ba_din_m;

    // round-robin instance outputs
    logic [NCH-1:0]    r_ch_ack, r_ch_dst, r_ch_rdy;
    logic              r_dbg_busy;
    logic [15:0]       r_dbg_dout;
    logic [NCH:0]      r_owner;
    logic [AW-1:0]     r_ba_addr;
    logic              r_ba_rd, r_ba_wr;
    logic [15:0]       r_ba_din;
    logic [1:0]        r_ba_din_m;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    jtframe_sdram_arb #(.AW(AW), .NCH(NCH), .RR(0), .MAXWAIT(3)) u_fix (
        .clk(clk), .rst(rst),
        .ch_addr(ch_addr), .ch_rd(ch_rd), .ch_wr(ch_wr), .ch_din(ch_din), .ch_din_m(ch_din_m),
        .ch_ack(ch_ack), .ch_dst(ch_dst), .ch_rdy(ch_rdy),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_din(dbg_din),
        .dbg_din_m(dbg_din_m), .locked(locked), .dbg_busy(dbg_busy), .dbg_dout(dbg_dout),
        .owner(owner), .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_din(ba_din),
        .ba_din_m(ba_din_m), .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_rdy(ba_rdy),
        .data_read(data_read)
    );

    jtframe_sdram_arb #(.AW(AW), .NCH(NCH), .RR(1), .MAXWAIT(15)) u_rr (
        .clk(clk), .rst(rst),
        .ch_addr(ch_addr), .ch_rd(ch_rd), .ch_wr(ch_wr), .ch_din(ch_din), .ch_din_m(ch_din_m),
        .ch_ack(r_ch_ack), .ch_dst(r_ch_dst), .ch_rdy(r_ch_rdy),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_din(dbg_din),
        .dbg_din_m(dbg_din_m), .locked(locked), .dbg_busy(r_dbg_busy), .dbg_dout(r_dbg_dout),
        .owner(r_owner), .ba_addr(r_ba_addr), .ba_rd(r_ba_rd), .ba_wr(r_ba_wr), .ba_din(r_ba_din),
        .ba_din_m(r_ba_din_m), .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_rdy(ba_rdy),
        .data_read(data_read)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ch_addr = {22'h200, 22'h100};
        ch_rd = '0; ch_wr = '0;
        ch_din = {16'hC1C1, 16'hC0C0}; ch_din_m = 4'b1111;
        dbg_req = 0; dbg_we = 0; locked = 0;
        dbg_addr = '0; dbg_din = '0; dbg_din_m = '0;
        ba_ack = 0; ba_dst = 0; ba_rdy = 0; data_read = '0;
        step(); step();
        rst = 1'b0;
        step();

        // reset state
        chk("rst_owner",  owner,    3'b000);
        chk("rst_busy",   dbg_busy, 1'b0);
        chk("rst_dout",   dbg_dout, 16'h0);
        chk("rst_ba_rd",  ba_rd,    1'b0);
        chk("rst_ba_adr", ba_addr,  22'h0);
        chk("rst_rdy",    ch_rdy,   2'b00);

        // fixed priority: both game channels request together
        ch_rd = 2'b11;
        step();
        chk("fp_owner0", owner,   3'b001);
        chk("fp_rd0",    ba_rd,   1'b1);
        chk("fp_addr0",  ba_addr, 22'h100);
        chk("fp_din0",   ba_din,  16'hC0C0);
        ba_ack = 1; #1;
        chk("fp_ack0",   ch_ack,  2'b01);
        step();
        ba_ack = 0; ba_rdy = 1; #1;
        chk("fp_rdy0",   ch_rdy,  2'b01);
        step();
        ba_rdy = 0; ch_rd = 2'b10; #1;
        chk("fp_idle_owner", owner, 3'b001);
        chk("fp_idle_rd",    ba_rd, 1'b0);
        step();
        chk("fp_owner1", owner,   3'b010);
        chk("fp_addr1",  ba_addr, 22'h200);
        ba_rdy = 1; #1;
        chk("fp_rdy1",   ch_rdy,  2'b10);
        step();
        ba_rdy = 0; ch_rd = 2'b00;
        step();
        chk("fp_keep_owner", owner, 3'b010);
        do_reset();

        // round-robin: both channels held for six transactions
        ch_rd = 2'b11;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("rr_owner%0d", i), r_owner, (i % 2 == 0) ? 3'b001 : 3'b010);
            ba_rdy = 1;
            step();
            ba_rdy = 0;
        end
        ch_rd = 2'b00;
        do_reset();

        // starvation guard: ch0 always requesting, debug read forced through
        ch_rd = 2'b01; dbg_req = 1; dbg_we = 0; dbg_addr = 22'h3AB;
        step();
        dbg_req = 0;
        chk("sv_busy",   dbg_busy, 1'b1);
        chk("sv_first",  owner,    3'b001);
        for (int k = 0; k < 3; k++) begin
            ba_rdy = 1;
            step();
            ba_rdy = 0;
            step();
            chk($sformatf("sv_lose%0d", k), owner, 3'b001);
        end
        ba_rdy = 1;
        step();
        ba_rdy = 0;
        step();
        chk("sv_win",    owner,   3'b100);
        chk("sv_addr",   ba_addr, 22'h3AB);
        chk("sv_rd",     ba_rd,   1'b1);
        chk("sv_wr",     ba_wr,   1'b0);
        ba_ack = 1; #1;
        chk("sv_noack",  ch_ack,  2'b00);
        step();
        ba_ack = 0; #1;
        chk("sv_rd_off", ba_rd,    1'b0);
        chk("sv_busy2",  dbg_busy, 1'b1);
        ba_dst = 1; data_read = 16'hBEEF;
        step();
        ba_dst = 0; data_read = 16'h0;
        chk("sv_dout",   dbg_dout, 16'hBEEF);
        ba_rdy = 1; #1;
        chk("sv_nordy",  ch_rdy,   2'b00);
        step();
        ba_rdy = 0;
        chk("sv_busy_off", dbg_busy, 1'b0);
        step();
        chk("sv_back_ch0", owner, 3'b001);
        ch_rd = 2'b00;
        ba_rdy = 1;
        step();
        ba_rdy = 0;
        do_reset();

        // lock gating
        locked = 1; dbg_req = 1;
        step();
        dbg_req = 0;
        chk("lk_busy", dbg_busy, 1'b0);
        step();
        chk("lk_owner", owner, 3'b000);
        locked = 0; dbg_req = 1; dbg_addr = 22'h040;
        step();
        dbg_req = 0;
        chk("ul_busy",  dbg_busy, 1'b1);
        chk("ul_owner_same", owner, 3'b000);
        step();
        chk("ul_owner", owner, 3'b100);
        chk("ul_rd",    ba_rd, 1'b1);
        ba_ack = 1;
        step();
        ba_ack = 0; ba_rdy = 1;
        step();
        ba_rdy = 0;
        chk("ul_done",  dbg_busy, 1'b0);
        do_reset();

        // debug write, second request while busy is dropped
        dbg_we = 1; dbg_din = 16'h1234; dbg_din_m = 2'b01; dbg_addr = 22'h055; dbg_req = 1;
        step();
        dbg_req = 0; dbg_we = 0;
        step();
        chk("wr_owner", owner,    3'b100);
        chk("wr_wr",    ba_wr,    1'b1);
        chk("wr_rd",    ba_rd,    1'b0);
        chk("wr_din",   ba_din,   16'h1234);
        chk("wr_mask",  ba_din_m, 2'b01);
        chk("wr_addr",  ba_addr,  22'h055);
        dbg_req = 1; ba_ack = 1;
        step();
        dbg_req = 0; ba_ack = 0; #1;
        chk("wr_wr_off", ba_wr,    1'b0);
        chk("wr_busy",   dbg_busy, 1'b1);
        ba_rdy = 1;
        step();
        ba_rdy = 0;
        chk("wr_busy_off", dbg_busy, 1'b0);
        step();
        chk("wr_no_regrant_rd", ba_rd, 1'b0);
        chk("wr_no_regrant_wr", ba_wr, 1'b0);
        do_reset();

        // reset mid-transaction
        ch_rd = 2'b10;
        step();
        chk("mr_owner", owner, 3'b010);
        chk("mr_rd",    ba_rd, 1'b1);
        rst = 1; ch_rd = 2'b00;
        step();
        rst = 0;
        chk("mr_owner0", owner,    3'b000);
        chk("mr_rd0",    ba_rd,    1'b0);
        chk("mr_rdy0",   ch_rdy,   2'b00);
        chk("mr_busy0",  dbg_busy, 1'b0);
        ba_rdy = 1; #1;
        chk("mr_late_rdy", ch_rdy, 2'b00);
        step();
        ba_rdy = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/jtframe_sdram_arb.md
Name: jtframe_sdram_arb

Overview:
- Parametrised SDRAM bank arbiter, the successor to the fixed two-owner (game/debug CPU) arbitration inside the cheat block.
- Shares one SDRAM bank port between NCH game channels and one debug-CPU channel.
- Supports fixed or round-robin priority, a starvation guard for the debug channel, lock gating, and a latched debug read-back register.
- Sits between the game SDRAM clients, the debug CPU port logic and the SDRAM controller bank interface.

Parameters:
AW, 22, SDRAM word address width
NCH, 2, number of game channels (1..7); debug channel index is NCH
RR, 0, 0 = fixed priority (ch0 highest, debug lowest); 1 = round-robin over all NCH+1 channels
MAXWAIT, 15, debug starvation limit in lost arbitration decisions (1..255)

Ports:
clk  in  1  SDRAM clock
rst  in  1  synchronous active-high reset
ch_addr  in  NCH*AW  game addresses, channel n at [n*AW +: AW]
ch_rd  in  NCH  game read requests, held until rdy
ch_wr  in  NCH  game write requests, held until rdy
ch_din  in  NCH*16  game write data
ch_din_m  in  NCH*2  game byte masks
ch_ack  out  NCH  bank ack routed to owner
ch_dst  out  NCH  data strobe routed to owner
ch_rdy  out  NCH  ready routed to owner
dbg_req  in  1  single-cycle debug request pulse
dbg_we  in  1  1 = write, sampled with dbg_req
dbg_addr  in  AW  debug address, stable while dbg_busy
dbg_din  in  16  debug write data
dbg_din_m  in  2  debug byte mask
locked  in  1  1 = dbg_req ignored
dbg_busy  out  1  debug transaction pending or active
dbg_dout  out  16  last debug read word
owner  out  NCH+1  one-hot current owner, bit NCH = debug
ba_addr  out  AW  bank address
ba_rd  out  1  bank read
ba_wr  out  1  bank write
ba_din  out  16  bank write data
ba_din_m  out  2  bank byte mask
ba_ack  in  1  bank request accepted
ba_dst  in  1  bank data strobe
ba_rdy  in  1  bank transaction done
data_read  in  16  bank read data

Behaviour:
- Reset values: state IDLE, owner=0, dbg_busy=0, dbg pending=0, dbg_dout=0, wait counter=0, RR pointer=0. With owner=0, all ba_* and ch_* outputs are 0.
- Debug request:
  - dbg_req with !locked && !dbg_busy sets pending, latches dbg_we and sets dbg_busy next cycle.
  - dbg_req while busy or locked is dropped.
  - pending clears on ba_ack while the debug channel is owner.
  - dbg_busy clears on ba_rdy while the debug channel is owner.
- FSM IDLE:
  - Candidates are ch_rd|ch_wr per channel plus debug pending.
  - If any candidate: register the one-hot winner into owner and go to BUSY. The winner's request drives ba_* from the next cycle.
  - No candidate: owner keeps its value, ba_rd/ba_wr=0.
- FSM BUSY:
  - Game owner: ba_* mux passes ch_* fields directly.
  - Debug owner: ba_rd = pending & ~we, ba_wr = pending & we.
  - ba_rdy returns to IDLE. Minimum one IDLE cycle between transactions.
- Routing: ch_ack/dst/rdy[n] = ba_x & owner[n] & BUSY. Bank strobes in IDLE are ignored.
- dbg_dout latches data_read on ba_dst when owner[NCH] & BUSY.
- Priority:
  - RR=0: lowest index wins.
  - RR=1: search starts at last winner+1 modulo NCH+1. The pointer updates on every grant.
- Starvation: in each IDLE decision where debug is pending but loses, the counter increments (saturating).
  - When counter==MAXWAIT, debug wins the next decision regardless of mode.
  - Counter clears on any debug grant and on reset.
- Simultaneous events: dbg_req in the same cycle as a grant decision does not participate until the next decision. ba_rdy and a new request in the same cycle: the request is seen at the next IDLE cycle.
- Reset mid-transaction aborts with no completion pulse. All outputs return to reset values the next cycle.

Test Plan:
- RR=0, NCH=2: ch0_rd and ch1_rd asserted together. Required: owner=001 first; ba_rdy; owner=010. ch_rdy pulses only on the matching channel.
- RR=1: ch0 and ch1 held continuously for 6 transactions. Required: owner sequence 001,010,001,010,… Debug, with no request, is never granted.
- RR=0, MAXWAIT=3: ch0 always requesting, dbg_req read. Required: debug granted on the 4th decision. ba_addr=dbg_addr, ba_rd=1 only while pending; data_read=16'hBEEF on ba_dst gives dbg_dout=BEEF; dbg_busy falls after ba_rdy.
- locked=1 with dbg_req pulse. Required: dbg_busy stays 0 and no debug grant. Repeat with locked=0: dbg_busy=1 next cycle.
- Debug write, dbg_din=1234, mask=2'b01. Required: ba_wr=1, ba_din=1234, ba_din_m=01. Pending clears on ba_ack while ba_wr drops the same cycle after; a second dbg_req while busy is ignored.
- rst asserted in BUSY with owner=ch1. Required: next cycle owner=0, ba_rd=0, ch_rdy=0, dbg_busy=0; a later ba_rdy produces no ch_rdy.
